// File: rtl/core_pkg.sv
// Shared PIC16F core constants: instruction-sequencer state encoding,
// interrupt vector address and the last Q phase of an instruction cycle.
package core_pkg;

  localparam logic [1:0]  SEQ_RUN         = 2'd0;
  localparam logic [1:0]  SEQ_FLUSH       = 2'd1;
  localparam logic [1:0]  SEQ_SLEEP       = 2'd2;

  localparam logic [13:0] IRQ_VECTOR_ADDR = 14'h004;

  localparam logic [1:0]  Q_LAST          = 2'd3;

endpackage : core_pkg

// File: rtl/q_phase_counter.sv
// Two-bit Q-phase counter. It wraps mod 4, and it can be held or synchronously cleared.
module q_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hold,
  output logic [1:0] q
);

  logic [1:0] q_r;

  // Q phase register; clear wins over hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 2'd0;
    end else if (clear) begin
      q_r <= 2'd0;
    end else if (!hold) begin
      q_r <= q_r + 2'd1;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule : q_phase_counter

// File: rtl/instr_cycle_sequencer.sv
// Instruction-cycle scheduler: owns the Q counter and picks execute vs forced NOP
// at each boundary. Branch, skip, SLEEP and interrupt entry are resolved here.
module instr_cycle_sequencer
  import core_pkg::*;
#(
  parameter bit IRQ_VECTOR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       branch_req,
  input  logic       skip_req,
  input  logic       sleep_req,
  input  logic       irq,
  input  logic       gie,
  output logic [1:0] q_count,
  output logic       exec_valid,
  output logic       instr_rd_en,
  output logic       instr_flush,
  output logic       pc_incr_en,
  output logic       pc_j_en,
  output logic       pc_vec_en,
  output logic       pc_push_en,
  output logic       gie_clr,
  output logic       sleeping
);

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic [1:0] q_s;
  logic       boundary_s;
  logic       wake_s;
  logic       irq_take_s;

  // Pulses are suppressed while reset is asserted, so a reset clock never fetches or moves the PC.
  assign boundary_s = (q_s == Q_LAST) && !rst;
  assign wake_s     = (state_r == SEQ_SLEEP) && irq;
  assign irq_take_s = irq && gie && IRQ_VECTOR_EN;

  q_phase_counter u_q_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (wake_s),
    .hold  (state_r == SEQ_SLEEP),
    .q     (q_s)
  );

  // Boundary decision and next-state selection
  always_comb begin
    next_state_s = state_r;
    instr_rd_en  = 1'b0;
    instr_flush  = 1'b0;
    pc_incr_en   = 1'b0;
    pc_j_en      = 1'b0;
    pc_vec_en    = 1'b0;
    pc_push_en   = 1'b0;
    gie_clr      = 1'b0;
    case (state_r)
      SEQ_RUN: begin
        if (boundary_s) begin
          instr_rd_en = 1'b1;
          if (branch_req) begin
            pc_j_en      = 1'b1;
            instr_flush  = 1'b1;
            next_state_s = SEQ_FLUSH;
          end else if (skip_req) begin
            pc_incr_en   = 1'b1;
            instr_flush  = 1'b1;
            next_state_s = SEQ_FLUSH;
          end else if (sleep_req) begin
            pc_incr_en   = 1'b1;
            next_state_s = SEQ_SLEEP;
          end else if (irq_take_s) begin
            // No increment, so the pushed PC still addresses the discarded prefetch
            pc_push_en   = 1'b1;
            pc_vec_en    = 1'b1;
            gie_clr      = 1'b1;
            instr_flush  = 1'b1;
            next_state_s = SEQ_FLUSH;
          end else begin
            pc_incr_en   = 1'b1;
            next_state_s = SEQ_RUN;
          end
        end else begin
          next_state_s = SEQ_RUN;
        end
      end
      SEQ_FLUSH: begin
        if (boundary_s) begin
          instr_rd_en  = 1'b1;
          pc_incr_en   = 1'b1;
          next_state_s = SEQ_RUN;
        end else begin
          next_state_s = SEQ_FLUSH;
        end
      end
      SEQ_SLEEP: begin
        if (irq) begin
          next_state_s = SEQ_RUN;
        end else begin
          next_state_s = SEQ_SLEEP;
        end
      end
      default: begin
        next_state_s = SEQ_FLUSH;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SEQ_FLUSH;
    end else begin
      state_r <= next_state_s;
    end
  end

  assign q_count    = q_s;
  assign exec_valid = (state_r == SEQ_RUN);
  assign sleeping   = (state_r == SEQ_SLEEP);

endmodule : instr_cycle_sequencer

// File: tb/tb_instr_cycle_sequencer.sv
// Table-driven bench for instr_cycle_sequencer: one row per clock of
// {inputs, expected q_count/exec_valid/sleeping/pulses}, plus a bounded hand sequence.
module tb_instr_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       branch_req, skip_req, sleep_req, irq, gie;
  logic [1:0] q_count;
  logic       exec_valid, instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
  logic       pc_vec_en, pc_push_en, gie_clr, sleeping;

  instr_cycle_sequencer #(.IRQ_VECTOR_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .branch_req  (branch_req),
    .skip_req    (skip_req),
    .sleep_req   (sleep_req),
    .irq         (irq),
    .gie         (gie),
    .q_count     (q_count),
    .exec_valid  (exec_valid),
    .instr_rd_en (instr_rd_en),
    .instr_flush (instr_flush),
    .pc_incr_en  (pc_incr_en),
    .pc_j_en     (pc_j_en),
    .pc_vec_en   (pc_vec_en),
    .pc_push_en  (pc_push_en),
    .gie_clr     (gie_clr),
    .sleeping    (sleeping)
  );

  always #5 clk = ~clk;

  // input bits {rst, branch, skip, sleep, irq, gie}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_SK   = 6'b001000;
  localparam logic [5:0] I_SL   = 6'b000100;
  localparam logic [5:0] I_IRQ  = 6'b000011;
  localparam logic [5:0] I_IRQN = 6'b000010;
  localparam logic [5:0] I_GIE  = 6'b000001;
  // pulse bits {rd, flush, incr, j, vec, push, gie_clr}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_NORM = 7'b1010000;
  localparam logic [6:0] P_BR   = 7'b1101000;
  localparam logic [6:0] P_SKIP = 7'b1110000;
  localparam logic [6:0] P_IRQ  = 7'b1100111;

  typedef struct {
    logic [5:0] in;
    logic [1:0] q;
    logic       ev;
    logic       slp;
    logic [6:0] p;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [6:0] pulses();
    return {instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_vec_en, pc_push_en, gie_clr};
  endfunction

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] in, input logic [1:0] q, input logic ev,
                     input logic slp, input logic [6:0] p);
    vec_t v;
    v.in = in; v.q = q; v.ev = ev; v.slp = slp; v.p = p;
    vecs.push_back(v);
  endtask

  // one 4-clock cycle: phases 0..2 with in_oth and no pulses, phase 3 with in3 / p3
  task automatic cyc(input logic ev, input logic [5:0] in3, input logic [6:0] p3,
                     input logic [5:0] in_oth);
    for (int k = 0; k < 3; k++) add(in_oth, 2'(k), ev, 1'b0, P_NONE);
    add(in3, 2'd3, ev, 1'b0, p3);
  endtask

  task automatic drive(input logic [5:0] in);
    {rst, branch_req, skip_req, sleep_req, irq, gie} = in;
  endtask

  initial begin
    int waited;
    // reset start plus three plain instructions
    cyc(1'b0, I_NONE, P_NORM, I_NONE);
    for (int i = 0; i < 3; i++) cyc(1'b1, I_NONE, P_NORM, I_NONE);
    // branch, then a branch request ignored during FLUSH
    cyc(1'b1, I_BR, P_BR, I_NONE);
    cyc(1'b0, I_BR, P_NORM, I_NONE);
    // simultaneous branch/skip/irq: branch wins, irq waits through FLUSH
    cyc(1'b1, I_BR | I_SK | I_IRQ, P_BR, I_NONE);
    cyc(1'b0, I_IRQ, P_NORM, I_IRQ);
    cyc(1'b1, I_IRQ, P_IRQ, I_IRQ);
    cyc(1'b0, I_NONE, P_NORM, I_NONE);
    // skip
    cyc(1'b1, I_SK, P_SKIP, I_NONE);
    cyc(1'b0, I_NONE, P_NORM, I_NONE);
    // sleep, 20 frozen clocks, wake on irq without gie
    cyc(1'b1, I_SL, P_NORM, I_NONE);
    for (int i = 0; i < 20; i++) add(I_GIE, 2'd0, 1'b0, 1'b1, P_NONE);
    add(I_IRQN, 2'd0, 1'b0, 1'b1, P_NONE);
    cyc(1'b1, I_IRQN, P_NORM, I_NONE);
    // sleep, wake with gie: woken instruction runs, then vector taken
    cyc(1'b1, I_SL, P_NORM, I_NONE);
    add(I_NONE, 2'd0, 1'b0, 1'b1, P_NONE);
    add(I_IRQ, 2'd0, 1'b0, 1'b1, P_NONE);
    cyc(1'b1, I_IRQ, P_IRQ, I_IRQ);
    // reset at q=2 of FLUSH
    add(I_NONE, 2'd0, 1'b0, 1'b0, P_NONE);
    add(I_NONE, 2'd1, 1'b0, 1'b0, P_NONE);
    add(I_RST,  2'd2, 1'b0, 1'b0, P_NONE);
    cyc(1'b0, I_NONE, P_NORM, I_NONE);
    // reset during SLEEP
    cyc(1'b1, I_SL, P_NORM, I_NONE);
    add(I_NONE, 2'd0, 1'b0, 1'b1, P_NONE);
    add(I_RST,  2'd0, 1'b0, 1'b1, P_NONE);
    cyc(1'b0, I_NONE, P_NORM, I_NONE);
    // reset at q=3 of RUN suppresses that boundary's pulses
    cyc(1'b1, I_RST, P_NONE, I_NONE);
    add(I_NONE, 2'd0, 1'b0, 1'b0, P_NONE);

    drive(I_RST);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      chk("q_count",    i, int'(q_count),    int'(vecs[i].q));
      chk("exec_valid", i, int'(exec_valid), int'(vecs[i].ev));
      chk("sleeping",   i, int'(sleeping),   int'(vecs[i].slp));
      chk("pulses",     i, int'(pulses()),   int'(vecs[i].p));
    end

    // hand sequence: from FLUSH q=0, the next fetch must be the FLUSH q=3 boundary
    @(negedge clk);
    drive(I_NONE);
    waited = 0;
    while (!instr_rd_en && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("fetch_wait", 0, waited, 2);
    chk("fetch_q", 0, int'(q_count), 3);
    chk("fetch_nop", 0, int'(exec_valid), 0);
    @(negedge clk);
    #1;
    chk("run_resume", 0, int'({exec_valid, q_count}), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_cycle_sequencer

// File: doc/instr_cycle_sequencer.md
# instr_cycle_sequencer

Instruction-cycle scheduler for the PIC16F core. Owns the four-clock Q-cycle counter and decides, at every instruction boundary, whether the next cycle executes the prefetched word or is a forced NOP. Branch, skip, SLEEP and interrupt entry are all handled here. It drives the fetch and PC enables that the instruction decoder currently generates, and it feeds the decoder `q_count` and `exec_valid`.

## Interface
Parameters:
- `IRQ_VECTOR_EN`, 1: when 0, interrupt entry is disabled and `irq` is used only as a wake source.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `branch_req`  in  1  current instruction jumps (GOTO/CALL/RETURN); sampled at q=3 only.
- `skip_req`  in  1  skip condition true (BTFSC/DECFSZ…); sampled at q=3 only.
- `sleep_req`  in  1  current instruction is SLEEP; sampled at q=3 only.
- `irq`  in  1  level interrupt request.
- `gie`  in  1  global interrupt enable (from INTCON).
- `q_count`  out  2  Q phase 0..3 of the current instruction cycle.
- `exec_valid`  out  1  1 = the current cycle executes the fetched word; 0 = forced NOP.
- `instr_rd_en`  out  1  load the instruction register from program memory.
- `instr_flush`  out  1  the fetched word is discarded; the next cycle is a NOP.
- `pc_incr_en`  out  1  PC <= PC+1.
- `pc_j_en`  out  1  PC <= jump target.
- `pc_vec_en`  out  1  PC <= 0x004 (interrupt vector).
- `pc_push_en`  out  1  push the current PC onto the hardware stack.
- `gie_clr`  out  1  clear GIE.
- `sleeping`  out  1  core is in SLEEP.

## Operation
- States are RUN, FLUSH and SLEEP. RUN has `exec_valid`=1. FLUSH has `exec_valid`=0 and lasts exactly one instruction cycle. SLEEP freezes `q_count` at 0.
- `q_count` increments mod 4 every clock except in SLEEP.
- All pulse outputs are 0 except at q=3. Each is a one-clock, combinational pulse.
- In RUN and FLUSH, `instr_rd_en` is 1 at q=3 of every cycle.
- Boundary decision at q=3 in RUN, in priority order:
  1. `branch_req`: `pc_j_en`, `instr_flush`; next state FLUSH.
  2. `skip_req`: `pc_incr_en`, `instr_flush`; next state FLUSH.
  3. `sleep_req`: `pc_incr_en`; next state SLEEP.
  4. `irq & gie & IRQ_VECTOR_EN`: `pc_push_en`, `pc_vec_en`, `gie_clr`, `instr_flush`; no increment; next state FLUSH. The pushed address is the address of the discarded prefetch.
  5. Otherwise: `pc_incr_en`; stay in RUN.
- Boundary decision at q=3 in FLUSH: `pc_incr_en`; next state RUN.
  - The request inputs are ignored, because a NOP cycle cannot branch, skip or sleep.
  - Interrupts are not taken in FLUSH. A pending `irq` waits for the end of the next RUN cycle.
- SLEEP: all pulse outputs are 0 and `sleeping`=1.
  - `irq` (regardless of `gie`) moves the state to RUN on the next clock, with q counting from 0.
  - The prefetched word (the one after SLEEP) then executes.
  - If `gie` is also set, the interrupt is taken at the end of that instruction.
- Simultaneous requests resolve only by the priority list above. Lower-priority requests are dropped, not queued; `irq` is level and is re-evaluated at the next boundary.

## Timing
- Reset values: state FLUSH, `q_count`=0, `exec_valid`=0, `sleeping`=0, all pulses 0. The first cycle after reset is a NOP whose q=3 fetches address 0 and increments the PC.
- Reset asserted mid-cycle or in SLEEP returns to the reset values on the next clock, with no pulses in that clock.
- Normal instruction: 4 clocks. Branch or skip taken: 8 clocks (instruction plus one FLUSH).
- Interrupt latency: from `irq` visible at q=3 of a RUN cycle, the vector fetch happens at the next q=3 (end of the FLUSH cycle).
- Wake from SLEEP: `irq` high at clock k gives `q_count`=0 in RUN at clock k+1.

## Structure
- Shared package `core_pkg`:
  - state encoding constants `SEQ_RUN`, `SEQ_FLUSH`, `SEQ_SLEEP`
  - `IRQ_VECTOR_ADDR` = 14'h004
  - the Q-phase constant `Q_LAST` = 2'd3.
- One sub-module, `q_phase_counter`: 2-bit counter with `hold` and synchronous clear. It is instantiated once.
- The decoder consumes `q_count` and `exec_valid`, and drops its own fetch and PC enables.

## Test plan
- Reset, then 3 instructions with all requests low:
  - `exec_valid` is 0 for clocks 0-3 and 1 afterwards.
  - `instr_rd_en` and `pc_incr_en` pulse at clocks 3, 7, 11 and 15.
- `branch_req`=1 at q=3 of the 2nd instruction:
  - `pc_j_en` and `instr_flush` pulse at that clock and `pc_incr_en`=0.
  - The next 4 clocks have `exec_valid`=0, then RUN resumes.
- `branch_req`, `skip_req` and `irq`(`gie`=1) all asserted at the same q=3:
  - only `pc_j_en` pulses; no push.
  - the interrupt is taken at the end of the next RUN cycle, not during FLUSH.
- `irq`=1 with `gie`=1 during RUN:
  - at q=3, `pc_push_en`, `pc_vec_en`, `gie_clr` and `instr_flush` pulse together and `pc_incr_en`=0.
  - the next cycle is FLUSH.
- `sleep_req` at q=3:
  - `pc_incr_en` pulses, `sleeping`=1, and `q_count` holds at 0 for 20 clocks.
  - `irq` with `gie`=0 then resumes RUN one clock later, and the following 4-clock cycle has `exec_valid`=1 with no vector.
- `rst` asserted at q=2 of a FLUSH cycle, and again during SLEEP: the next clock shows `q_count`=0, state FLUSH, `sleeping`=0 and no pulses.
